// File: rtl/rv32i_types.sv
// Shared RV32I types: reservation-station packet, CDB record,
// load/store funct3 encodings and memory-queue sizing.
package rv32i_types;

    localparam int MEMQ_DEPTH = 8;
    localparam int NUM_CDB    = 4;
    localparam int ROB_AW     = 5;
    localparam int PRF_AW     = 6;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [31:0]       pc;
        logic [2:0]        funct3;
        logic [3:0]        r_mask;
        logic [3:0]        w_mask;
        logic [PRF_AW-1:0] rd_paddr;
        logic              rs1_ready;
        logic [PRF_AW-1:0] rs1_paddr;
        logic [31:0]       rs1_data;
        logic              rs2_ready;
        logic [PRF_AW-1:0] rs2_paddr;
        logic [31:0]       rs2_data;
        logic [ROB_AW-1:0] rob_addr;
    } rs_t;

    typedef struct packed {
        logic              valid;
        logic              rd_valid;
        logic [PRF_AW-1:0] rd_paddr;
        logic [31:0]       rd_data;
    } cdb_t;

endpackage

// File: rtl/cdb_snoop.sv
// Per-operand CDB compare/capture. Ports: paddr/ready/data = current
// operand state, cdb = broadcast buses; ready_n/data_n = state after snoop.
module cdb_snoop
    import rv32i_types::*;
#(
    parameter int N = NUM_CDB
) (
    input  logic [PRF_AW-1:0] paddr,
    input  logic              ready,
    input  logic [31:0]       data,
    input  cdb_t              cdb [N],
    output logic              ready_n,
    output logic [31:0]       data_n
);

    logic hit;

    // Lowest-index bus wins; physical register 0 never wakes anything.
    always_comb begin
        ready_n = ready;
        data_n  = data;
        hit     = 1'b0;
        if (!ready && paddr != '0) begin
            for (int i = 0; i < N; i++) begin
                if (!hit && cdb[i].valid && cdb[i].rd_valid &&
                    cdb[i].rd_paddr == paddr) begin
                    hit     = 1'b1;
                    ready_n = 1'b1;
                    data_n  = cdb[i].rd_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_queue.sv
// In-order memory-op queue feeding the memory unit.
// Ports: enq_* dispatch side, cdb snoop, rob_head_addr/flush control,
// mem_ready/issue_valid/mem_next issue side, count occupancy.
module mem_queue
    import rv32i_types::*;
#(
    parameter int DEPTH   = MEMQ_DEPTH,
    parameter int NUM_CDB = rv32i_types::NUM_CDB,
    parameter int ROB_AW  = rv32i_types::ROB_AW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    input  rs_t                    enq_pkt,
    output logic                   enq_ready,
    input  cdb_t                   cdb [NUM_CDB],
    input  logic [ROB_AW-1:0]      rob_head_addr,
    input  logic                   flush,
    input  logic                   mem_ready,
    output logic                   issue_valid,
    output rs_t                    mem_next,
    output logic [$clog2(DEPTH):0] count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    rs_t              ent_q [DEPTH];
    rs_t              ent_d [DEPTH];
    rs_t              ent_s [DEPTH];
    rs_t              enq_s;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;

    logic [IW-1:0] hidx, tidx;
    logic          full;
    logic          head_ready;
    logic          is_load;
    logic          enq_fire;

    // Every stored entry snoops both operands each cycle.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic        r1, r2;
        logic [31:0] d1, d2;
        rs_t         s;

        cdb_snoop #(.N(NUM_CDB)) u_s1 (
            .paddr  (ent_q[g].rs1_paddr),
            .ready  (ent_q[g].rs1_ready),
            .data   (ent_q[g].rs1_data),
            .cdb    (cdb),
            .ready_n(r1),
            .data_n (d1)
        );

        cdb_snoop #(.N(NUM_CDB)) u_s2 (
            .paddr  (ent_q[g].rs2_paddr),
            .ready  (ent_q[g].rs2_ready),
            .data   (ent_q[g].rs2_data),
            .cdb    (cdb),
            .ready_n(r2),
            .data_n (d2)
        );

        always_comb begin
            s           = ent_q[g];
            s.rs1_ready = r1;
            s.rs1_data  = d1;
            s.rs2_ready = r2;
            s.rs2_data  = d2;
        end

        assign ent_s[g] = s;
    end

    // The packet being dispatched snoops too, so a same-cycle
    // broadcast is not lost.
    logic        er1, er2;
    logic [31:0] ed1, ed2;

    cdb_snoop #(.N(NUM_CDB)) u_enq_s1 (
        .paddr  (enq_pkt.rs1_paddr),
        .ready  (enq_pkt.rs1_ready),
        .data   (enq_pkt.rs1_data),
        .cdb    (cdb),
        .ready_n(er1),
        .data_n (ed1)
    );

    cdb_snoop #(.N(NUM_CDB)) u_enq_s2 (
        .paddr  (enq_pkt.rs2_paddr),
        .ready  (enq_pkt.rs2_ready),
        .data   (enq_pkt.rs2_data),
        .cdb    (cdb),
        .ready_n(er2),
        .data_n (ed2)
    );

    always_comb begin
        enq_s           = enq_pkt;
        enq_s.rs1_ready = er1;
        enq_s.rs1_data  = ed1;
        enq_s.rs2_ready = er2;
        enq_s.rs2_data  = ed2;
    end

    assign hidx  = head_q[IW-1:0];
    assign tidx  = tail_q[IW-1:0];
    assign full  = (hidx == tidx) && (head_q[IW] != tail_q[IW]);
    assign count = tail_q - head_q;

    assign enq_ready = !full;
    assign enq_fire  = enq_valid && !full && !flush && !rst;

    // Head readiness uses registered state only: no CDB-to-issue bypass.
    assign mem_next   = ent_q[hidx];
    assign is_load    = |mem_next.r_mask;
    assign head_ready = valid_q[hidx] && mem_next.rs1_ready &&
                        mem_next.rs2_ready &&
                        (is_load || mem_next.rob_addr == rob_head_addr);

    assign issue_valid = head_ready && mem_ready && !flush && !rst;

    always_comb begin
        ent_d   = ent_s;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (issue_valid) begin
            valid_d[hidx] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        if (enq_fire) begin
            ent_d[tidx]   = enq_s;
            valid_d[tidx] = 1'b1;
            tail_d        = tail_q + 1'b1;
        end
        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_mem_queue.sv
// Directed self-checking bench for mem_queue.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_queue;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid;
    rs_t         enq_pkt;
    logic        enq_ready;
    cdb_t        cdb [NUM_CDB];
    logic [4:0]  rob_head_addr;
    logic        flush;
    logic        mem_ready;
    logic        issue_valid;
    rs_t         mem_next;
    logic [3:0]  count;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_queue dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_pkt      (enq_pkt),
        .enq_ready    (enq_ready),
        .cdb          (cdb),
        .rob_head_addr(rob_head_addr),
        .flush        (flush),
        .mem_ready    (mem_ready),
        .issue_valid  (issue_valid),
        .mem_next     (mem_next),
        .count        (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic rs_t mk(input logic ld, input logic r1,
                               input logic [5:0] p1, input logic [31:0] d1,
                               input logic r2, input logic [5:0] p2,
                               input logic [31:0] d2, input logic [4:0] rob);
        rs_t p;
        p           = '0;
        p.funct3    = ld ? F3_LW : F3_SW;
        p.r_mask    = ld ? 4'hf : 4'h0;
        p.w_mask    = ld ? 4'h0 : 4'hf;
        p.rs1_ready = r1;
        p.rs1_paddr = p1;
        p.rs1_data  = d1;
        p.rs2_ready = r2;
        p.rs2_paddr = p2;
        p.rs2_data  = d2;
        p.rob_addr  = rob;
        return p;
    endfunction

    task automatic cdb_clr();
        for (int i = 0; i < NUM_CDB; i++) cdb[i] = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    int q[$];
    int id;
    int pend;

    initial begin
        rst = 1'b1;
        enq_valid = 1'b0;
        enq_pkt = '0;
        rob_head_addr = '0;
        flush = 1'b0;
        mem_ready = 1'b0;
        cdb_clr();
        repeat (2) nxt();
        rst = 1'b0;
        #1;
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_issue", 32'(issue_valid), 0);
        chk("rst_count", 32'(count), 0);

        // simple ready load
        nxt();
        enq_valid = 1'b1;
        enq_pkt = mk(1, 1, 6'd1, 32'h1000, 1, 6'd0, 32'd4, 5'd0);
        mem_ready = 1'b1;
        #1;
        chk("t1_empty_issue", 32'(issue_valid), 0);
        nxt();
        enq_valid = 1'b0;
        #1;
        chk("t1_issue", 32'(issue_valid), 1);
        chk("t1_rs1", mem_next.rs1_data, 32'h1000);
        chk("t1_rs2", mem_next.rs2_data, 32'd4);
        chk("t1_cnt1", 32'(count), 1);
        nxt();
        #1;
        chk("t1_cnt0", 32'(count), 0);
        chk("t1_idle", 32'(issue_valid), 0);

        // wakeup through cdb[2]
        nxt();
        enq_valid = 1'b1;
        enq_pkt = mk(1, 0, 6'd7, 32'h0, 1, 6'd0, 32'd8, 5'd1);
        nxt();
        enq_valid = 1'b0;
        cdb[2].valid = 1'b1;
        cdb[2].rd_valid = 1'b1;
        cdb[2].rd_paddr = 6'd7;
        cdb[2].rd_data = 32'hDEAD0000;
        #1;
        chk("t2_no_bypass", 32'(issue_valid), 0);
        nxt();
        cdb_clr();
        #1;
        chk("t2_issue", 32'(issue_valid), 1);
        chk("t2_rs1", mem_next.rs1_data, 32'hDEAD0000);
        nxt();
        #1;
        chk("t2_cnt0", 32'(count), 0);

        // store waits for ROB head; younger load stays behind it
        rob_head_addr = 5'd1;
        enq_valid = 1'b1;
        enq_pkt = mk(0, 1, 6'd2, 32'h2000, 1, 6'd3, 32'h55, 5'd3);
        nxt();
        enq_pkt = mk(1, 1, 6'd4, 32'h3000, 1, 6'd0, 32'd0, 5'd4);
        #1;
        chk("t3_st_blocked", 32'(issue_valid), 0);
        nxt();
        enq_valid = 1'b0;
        #1;
        chk("t3_ld_blocked", 32'(issue_valid), 0);
        chk("t3_cnt2", 32'(count), 2);
        nxt();
        rob_head_addr = 5'd3;
        #1;
        chk("t3_st_issue", 32'(issue_valid), 1);
        chk("t3_st_rob", 32'(mem_next.rob_addr), 3);
        nxt();
        mem_ready = 1'b0;
        #1;
        chk("t3_busy", 32'(issue_valid), 0);
        chk("t3_head_ld", 32'(mem_next.rob_addr), 4);
        chk("t3_cnt1", 32'(count), 1);
        nxt();
        mem_ready = 1'b1;
        #1;
        chk("t3_ld_issue", 32'(issue_valid), 1);
        nxt();
        mem_ready = 1'b0;
        #1;
        chk("t3_cnt0", 32'(count), 0);

        // fill to full, then stream 20 ops through the wrap
        q.delete();
        for (int i = 1; i <= 8; i++) begin
            enq_valid = 1'b1;
            enq_pkt = mk(1, 1, 6'd5, 32'(100 + i), 1, 6'd0, 32'd0, 5'(i));
            q.push_back(100 + i);
            nxt();
        end
        enq_pkt = mk(1, 1, 6'd5, 32'd109, 1, 6'd0, 32'd0, 5'd9);
        #1;
        chk("t4_full_rdy", 32'(enq_ready), 0);
        chk("t4_full_cnt", 32'(count), 8);
        mem_ready = 1'b1;
        #1;
        chk("t4_full_iss", 32'(issue_valid), 1);
        chk("t4_no_pass", 32'(enq_ready), 0);
        chk("t4_first", mem_next.rs1_data, 32'd101);
        void'(q.pop_front());
        nxt();
        mem_ready = 1'b0;
        #1;
        chk("t4_rdy_again", 32'(enq_ready), 1);
        chk("t4_cnt7", 32'(count), 7);
        q.push_back(109);
        nxt();
        enq_valid = 1'b0;
        #1;
        chk("t4_cnt8", 32'(count), 8);
        id = 10;
        mem_ready = 1'b1;
        for (int c = 0; c < 60 && (q.size() > 0 || id <= 20); c++) begin
            enq_valid = (id <= 20);
            enq_pkt = mk(1, 1, 6'd5, 32'(100 + id), 1, 6'd0, 32'd0, 5'(id));
            #1;
            chk("t4_cnt", 32'(count), 32'(q.size()));
            chk("t4_iss", 32'(issue_valid), 32'(q.size() > 0));
            chk("t4_rdy", 32'(enq_ready), 32'(q.size() < 8));
            pend = q.size();
            if (pend > 0) begin
                chk("t4_order", mem_next.rs1_data, 32'(q[0]));
                void'(q.pop_front());
            end
            if (enq_valid && pend < 8) begin
                q.push_back(100 + id);
                id++;
            end
            nxt();
        end
        enq_valid = 1'b0;
        #1;
        chk("t4_drained", 32'(count), 0);
        chk("t4_all_sent", 32'(id), 21);

        // flush beats enqueue and issue
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1;
            enq_pkt = mk(1, 1, 6'd5, 32'(200 + i), 1, 6'd0, 32'd0, 5'(i));
            nxt();
        end
        mem_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("t5_cnt5", 32'(count), 5);
        chk("t5_no_issue", 32'(issue_valid), 0);
        nxt();
        flush = 1'b0;
        enq_valid = 1'b0;
        #1;
        chk("t5_cnt0", 32'(count), 0);
        chk("t5_rdy", 32'(enq_ready), 1);
        chk("t5_idle", 32'(issue_valid), 0);

        // same-cycle snoop on enqueue; cdb[0] lacks rd_valid
        enq_valid = 1'b1;
        enq_pkt = mk(1, 0, 6'd9, 32'h0, 1, 6'd0, 32'd12, 5'd6);
        cdb[0].valid = 1'b1;
        cdb[0].rd_paddr = 6'd9;
        cdb[0].rd_data = 32'h11111111;
        cdb[1].valid = 1'b1;
        cdb[1].rd_valid = 1'b1;
        cdb[1].rd_paddr = 6'd9;
        cdb[1].rd_data = 32'hCAFEF00D;
        nxt();
        enq_valid = 1'b0;
        cdb_clr();
        #1;
        chk("t6_issue", 32'(issue_valid), 1);
        chk("t6_rs1", mem_next.rs1_data, 32'hCAFEF00D);
        nxt();

        // paddr 0 never wakes
        enq_valid = 1'b1;
        enq_pkt = mk(1, 0, 6'd0, 32'h0, 1, 6'd0, 32'd0, 5'd7);
        cdb[0].valid = 1'b1;
        cdb[0].rd_valid = 1'b1;
        cdb[0].rd_paddr = 6'd0;
        cdb[0].rd_data = 32'h77;
        nxt();
        enq_valid = 1'b0;
        #1;
        chk("t7_p0_block", 32'(issue_valid), 0);
        nxt();
        cdb_clr();
        #1;
        chk("t7_p0_still", 32'(issue_valid), 0);
        chk("t7_cnt1", 32'(count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
